uart_transmitter: RTL and testbench
===================================

// Module: uart_transmitter
// PURPOSE
//   Serialises one byte per request onto the UART line as start, data LSB-first, optional parity, stop.
//   Tx-side counterpart of the UART receiver; runs on the same 16x-oversampled baudClk.
//   Each bit is held for OVERSAMPLE clocks. Default framing (8N1) is line-compatible with the receiver.
//   Sits between the memory/host side (parallel byte + start strobe) and the tx pin.
// PARAMETERS
//   OVERSAMPLE  16  baudClk cycles per bit; power of two, 2..16
//   DATA_BITS   8   payload bits per frame, 5..8
//   PARITY      0   0 = none, 1 = even, 2 = odd
//   STOP_BITS   1   stop bits, 1 or 2
// PORTS
//   baudClk  in   1          oversampled baud clock; all logic on posedge
//   reset    in   1          asynchronous, active-low reset
//   txData   in   DATA_BITS  byte to send; sampled only at acceptance
//   txStart  in   1          request; accepted when txStart && txReady at posedge
//   txReady  out  1          high only in IDLE
//   txBusy   out  1          high from acceptance until return to IDLE
//   txDone   out  1          one-cycle pulse at the end of the final stop bit
//   tx       out  1          serial line; idle high; driven directly from a flop
// BEHAVIOUR
// - Reset (reset==0, async): tx=1, txReady=1, txBusy=0, txDone=0.
//   Also clears state to IDLE, all counters to 0, and the shift register.
//   A mid-frame reset aborts the frame; tx is high immediately. There is no partial-frame recovery.
// - IDLE: tx=1, txReady=1, txDone=0.
//   On acceptance: latch txData into the shift register, compute parity, bitCnt=0, clkCnt=0.
//   At the same edge: tx<=0, txBusy<=1, txReady<=0, state->START_BIT.
// - START_BIT: tx=0 for OVERSAMPLE cycles. When clkCnt==OVERSAMPLE-1: clkCnt=0, state->DATA_BITS.
// - DATA_BITS: tx = shift[0]. Each bit period ends with clkCnt==OVERSAMPLE-1; then shift right, bitCnt+1.
//   After bit DATA_BITS-1, the parity slot (if PARITY!=0) is sent as one extra period, still in DATA_BITS.
//   Then state->STOP_BIT.
// - STOP_BIT: tx=1 for STOP_BITS*OVERSAMPLE cycles.
//   On its last cycle's edge: state->IDLE, txBusy<=0, txReady<=1, txDone<=1 (cleared the next cycle).
// - Frame length is exactly OVERSAMPLE*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles from acceptance.
// - Parity: even = ^data; odd = ~^data. Computed on the latched value.
// - Back-to-back: a txStart held high is accepted on the first IDLE cycle.
//   Minimum line-high gap = stop bits + 1 baudClk.
// - txStart while busy is ignored, not queued. txData changes after acceptance do not affect the frame.
// - Counters wrap only through the explicit reset-to-0 above.
//   clkCnt is $clog2(OVERSAMPLE) bits; bitCnt is 4 bits.
// - Unused state encodings go to IDLE with tx=1.
// STRUCTURE
// - Shared constants file UartStates.v holds IDLE/START_BIT/DATA_BITS/STOP_BIT (2-bit).
//   Add there: `PARITY_NONE/`PARITY_EVEN/`PARITY_ODD. Receiver and transmitter must share the encodings.
// - One sub-module: uart_bit_timer (clkCnt, clear input, bitEnd output when clkCnt==OVERSAMPLE-1).
//   A future parity-aware receiver reuses it.
// - Single FSM and shift register in uart_transmitter. tx, txDone, txBusy and txReady are all registered.
// TESTING
// 1. Assert reset, release -> tx=1, txReady=1, txBusy=0, txDone=0. Hold 100 cycles with txStart=0 -> no change.
// 2. Defaults, txData=0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each held 16 cycles.
//    txDone pulses exactly once, 160 cycles after acceptance.
// 3. Loopback into the receiver; send 0x00, 0xFF, 0x3C back-to-back with txStart held high.
//    -> receiver toMem returns each byte with rxDone. tx high for 17 cycles between frames.
// 4. Send 0xA5, then pulse txStart with txData=0x11 at cycle 40 -> ignored.
//    Waveform is identical to scenario 2; no second frame follows.
// 5. Assert reset at cycle 50 of a 0xA5 frame -> tx=1 in the same cycle.
//    After release, send 0x5A -> clean frame with correct bits.
// 6. PARITY=1, txData=0x07 -> parity slot=1; PARITY=2 -> parity slot=0.
//    Frame = 176 cycles; STOP_BITS=2 -> 192 cycles.

Source files
------------

// File: rtl/uart_transmitter_pkg.sv
// Shared UART encodings: FSM states and parity modes used by both the transmitter and receiver.
package uart_transmitter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b10,
        ST_STOP  = 2'b11
    } uartState_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Narrower payloads are zero-extended, which leaves the XOR reduction unchanged.
    function automatic logic calcParity(input logic [7:0] data, input int mode);
        return (mode == PARITY_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Oversample counter marking the last baudClk cycle of each bit period; shared by tx and rx.
module uart_bit_timer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic baudClk,
    input  logic reset,
    input  logic clear,
    output logic bitEnd
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OVERSAMPLE - 1);

    logic [CNT_W-1:0] clkCnt;

    assign bitEnd = (clkCnt == LAST_CNT);

    always_ff @(posedge baudClk or negedge reset) begin
        if (!reset) begin
            clkCnt <= '0;
        end else if (clear || bitEnd) begin
            clkCnt <= '0;
        end else begin
            clkCnt <= clkCnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, LSB-first payload, optional parity, stop bit(s), all from registered outputs.
module uart_transmitter
    import uart_transmitter_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 baudClk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] txData,
    input  logic                 txStart,
    output logic                 txReady,
    output logic                 txBusy,
    output logic                 txDone,
    output logic                 tx
);

    localparam int NUM_SLOTS = DATA_BITS + ((PARITY != PARITY_NONE) ? 1 : 0);
    localparam logic [3:0] LAST_SLOT = 4'(NUM_SLOTS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    uartState_t           state;
    logic [DATA_BITS:0]   shiftReg;
    logic [3:0]           bitCnt;
    logic                 bitEnd;
    logic                 parityBit;
    logic                 timerClear;

    assign parityBit  = calcParity(8'(txData), PARITY);
    assign timerClear = (state == ST_IDLE);

    uart_bit_timer #(
        .OVERSAMPLE(OVERSAMPLE)
    ) bitTimer (
        .baudClk(baudClk),
        .reset  (reset),
        .clear  (timerClear),
        .bitEnd (bitEnd)
    );

    // The parity slot rides above the payload in the shift register, so it goes out as one more data slot.
    always_ff @(posedge baudClk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            shiftReg <= '0;
            bitCnt   <= '0;
            tx       <= 1'b1;
            txReady  <= 1'b1;
            txBusy   <= 1'b0;
            txDone   <= 1'b0;
        end else begin
            txDone <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (txStart && txReady) begin
                        shiftReg <= {(PARITY == PARITY_NONE) ? 1'b1 : parityBit, txData};
                        bitCnt   <= '0;
                        tx       <= 1'b0;
                        txBusy   <= 1'b1;
                        txReady  <= 1'b0;
                        state    <= ST_START;
                    end else begin
                        tx      <= 1'b1;
                        txBusy  <= 1'b0;
                        txReady <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bitEnd) begin
                        tx    <= shiftReg[0];
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bitEnd) begin
                        if (bitCnt == LAST_SLOT) begin
                            bitCnt <= '0;
                            tx     <= 1'b1;
                            state  <= ST_STOP;
                        end else begin
                            bitCnt   <= bitCnt + 4'd1;
                            shiftReg <= shiftReg >> 1;
                            tx       <= shiftReg[1];
                        end
                    end
                end
                ST_STOP: begin
                    if (bitEnd) begin
                        if (bitCnt == LAST_STOP) begin
                            bitCnt  <= '0;
                            txBusy  <= 1'b0;
                            txReady <= 1'b1;
                            txDone  <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            bitCnt <= bitCnt + 4'd1;
                        end
                    end
                end
                default: begin
                    tx      <= 1'b1;
                    txBusy  <= 1'b0;
                    txReady <= 1'b1;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: cycle-exact waveform checks plus a line-decoding scoreboard.
module tb_uart_transmitter;

    logic       baudClk = 1'b0;
    logic       reset   = 1'b0;
    logic [7:0] txData  = 8'h00;
    logic       txStart = 1'b0;
    logic       txReady, txBusy, txDone, tx;

    logic [7:0] pData  = 8'h00;
    logic       pStart = 1'b0;
    logic [2:0] pTx, pDone, pBusy, pReady;

    int total = 0;
    int bad   = 0;
    logic [7:0] expQ[$];

    always #5 baudClk = ~baudClk;

    uart_transmitter dut (
        .baudClk(baudClk), .reset(reset), .txData(txData), .txStart(txStart),
        .txReady(txReady), .txBusy(txBusy), .txDone(txDone), .tx(tx)
    );

    uart_transmitter #(.PARITY(1), .STOP_BITS(1)) dutEven (
        .baudClk(baudClk), .reset(reset), .txData(pData), .txStart(pStart),
        .txReady(pReady[0]), .txBusy(pBusy[0]), .txDone(pDone[0]), .tx(pTx[0])
    );

    uart_transmitter #(.PARITY(2), .STOP_BITS(1)) dutOdd (
        .baudClk(baudClk), .reset(reset), .txData(pData), .txStart(pStart),
        .txReady(pReady[1]), .txBusy(pBusy[1]), .txDone(pDone[1]), .tx(pTx[1])
    );

    uart_transmitter #(.PARITY(1), .STOP_BITS(2)) dutEven2 (
        .baudClk(baudClk), .reset(reset), .txData(pData), .txStart(pStart),
        .txReady(pReady[2]), .txBusy(pBusy[2]), .txDone(pDone[2]), .tx(pTx[2])
    );

    // Line decoder acting as the receiver: samples mid-bit and pops the expected byte per completed frame.
    initial begin : monitor
        logic [7:0] got;
        logic [7:0] expByte;
        logic       stopBit;
        bit         aborted;
        forever begin
            @(negedge baudClk);
            if (reset === 1'b1 && tx === 1'b0) begin
                aborted = 1'b0;
                got     = '0;
                stopBit = 1'b0;
                for (int c = 0; c <= 152; c++) begin
                    if (c > 0) @(negedge baudClk);
                    if (reset !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (c >= 24 && c <= 136 && ((c - 24) % 16) == 0) got[(c - 24) / 16] = tx;
                    if (c == 152) stopBit = tx;
                end
                if (!aborted) begin
                    total++;
                    if (expQ.size() == 0) begin
                        bad++;
                        $display("[TB] FAIL rxFrame: got data=%02h stop=%b but no frame expected", got, stopBit);
                    end else begin
                        expByte = expQ.pop_front();
                        if ({stopBit, got} !== {1'b1, expByte}) begin
                            bad++;
                            $display("[TB] FAIL rxFrame: got data=%02h stop=%b, expected data=%02h stop=1",
                                     got, stopBit, expByte);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic test_reset();
        reset   = 1'b0;
        txStart = 1'b0;
        pStart  = 1'b0;
        repeat (3) @(negedge baudClk);
        total++;
        if ({tx, txReady, txBusy, txDone} !== 4'b1100) begin
            bad++;
            $display("[TB] FAIL resetHeld: {tx,ready,busy,done}=%b, expected 1100", {tx, txReady, txBusy, txDone});
        end
        reset = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge baudClk);
            total++;
            if ({tx, txReady, txBusy, txDone} !== 4'b1100) begin
                bad++;
                $display("[TB] FAIL idleHold k=%0d: {tx,ready,busy,done}=%b, expected 1100",
                         k, {tx, txReady, txBusy, txDone});
            end
        end
    endtask

    // Cycle k is sampled on the negedge after acceptance edge + k.
    task automatic test_single(input logic [7:0] d, input bit injectIgnored);
        logic [9:0] bits;
        logic [3:0] expv;
        logic [3:0] obs;
        bits = {1'b1, d, 1'b0};
        @(negedge baudClk);
        txData  = d;
        txStart = 1'b1;
        expQ.push_back(d);
        for (int k = 0; k <= 200; k++) begin
            @(negedge baudClk);
            if (k == 0) begin
                txStart = 1'b0;
                txData  = ~d;
            end
            if (k < 160)       expv = {bits[k / 16], 1'b0, 1'b1, 1'b0};
            else if (k == 160) expv = 4'b1101;
            else               expv = 4'b1001;
            obs = {tx, txDone, txBusy, txReady};
            total++;
            if (obs !== expv) begin
                bad++;
                $display("[TB] FAIL frame%02h k=%0d: {tx,done,busy,ready}=%b, expected %b", d, k, obs, expv);
            end
            if (injectIgnored && k == 40) begin
                txStart = 1'b1;
                txData  = 8'h11;
            end
            if (injectIgnored && k == 41) txStart = 1'b0;
        end
    endtask

    task automatic test_frame();
        test_single(8'hA5, 1'b0);
    endtask

    task automatic test_ignore_while_busy();
        test_single(8'hA5, 1'b1);
    endtask

    task automatic test_reset_midframe();
        @(negedge baudClk);
        txData  = 8'hA5;
        txStart = 1'b1;
        @(negedge baudClk);
        txStart = 1'b0;
        repeat (50) @(negedge baudClk);
        #2 reset = 1'b0;
        #1;
        total++;
        if ({tx, txDone, txBusy, txReady} !== 4'b1001) begin
            bad++;
            $display("[TB] FAIL midReset: {tx,done,busy,ready}=%b, expected 1001", {tx, txDone, txBusy, txReady});
        end
        repeat (3) @(negedge baudClk);
        reset = 1'b1;
        test_single(8'h5A, 1'b0);
    endtask

    task automatic test_back_to_back();
        int   acc;
        int   dones;
        int   highRun;
        logic prevBusy;
        @(negedge baudClk);
        txData  = 8'h00;
        txStart = 1'b1;
        expQ.push_back(8'h00);
        acc      = 0;
        dones    = 0;
        highRun  = 0;
        prevBusy = txBusy;
        for (int k = 0; k < 700 && dones < 3; k++) begin
            @(negedge baudClk);
            if (txBusy && !prevBusy) begin
                acc++;
                if (acc == 2) begin
                    total++;
                    if (highRun !== 17) begin
                        bad++;
                        $display("[TB] FAIL gap: line high for %0d cycles between frames, expected 17", highRun);
                    end
                end
                if (acc == 1) begin
                    txData = 8'hFF;
                    expQ.push_back(8'hFF);
                end else if (acc == 2) begin
                    txData = 8'h3C;
                    expQ.push_back(8'h3C);
                end else begin
                    txStart = 1'b0;
                end
            end
            if (txDone) dones++;
            highRun  = tx ? highRun + 1 : 0;
            prevBusy = txBusy;
        end
        txStart = 1'b0;
        total++;
        if (dones !== 3 || acc !== 3) begin
            bad++;
            $display("[TB] FAIL backToBack: dones=%0d accepts=%0d, expected 3 and 3", dones, acc);
        end
    endtask

    task automatic test_parity();
        logic [7:0] d;
        logic [9:0] bits;
        logic [2:0] expv;
        logic [2:0] obs;
        logic       par;
        logic       expTx;
        int         frameLen;
        int         slot;
        d    = 8'h07;
        bits = {1'b1, d, 1'b0};
        @(negedge baudClk);
        pData  = d;
        pStart = 1'b1;
        for (int k = 0; k <= 200; k++) begin
            @(negedge baudClk);
            if (k == 0) pStart = 1'b0;
            slot = k / 16;
            for (int u = 0; u < 3; u++) begin
                frameLen = (u == 2) ? 192 : 176;
                par      = (u == 1) ? 1'b0 : 1'b1;
                if (slot <= 8)      expTx = bits[slot];
                else if (slot == 9) expTx = par;
                else                expTx = 1'b1;
                expv = {expTx, (k == frameLen), (k < frameLen)};
                obs  = {pTx[u], pDone[u], pBusy[u]};
                total++;
                if (obs !== expv) begin
                    bad++;
                    $display("[TB] FAIL parity u=%0d k=%0d: {tx,done,busy}=%b, expected %b", u, k, obs, expv);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_ignore_while_busy();
        test_reset_midframe();
        test_back_to_back();
        test_parity();
        repeat (20) @(negedge baudClk);
        total++;
        if (expQ.size() !== 0) begin
            bad++;
            $display("[TB] FAIL scoreboard: %0d expected frames never decoded, expected 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
